clipper_seq_ctrl: RTL and testbench
===================================

Name: clipper_seq_ctrl

Overview:
- Sequences the 27-lane clipper in the FME interpolation pipeline, one row of filtered samples per beat.
- Accepts a block command (mode, row count) and drives the clipper's clip_pvso select and register enable.
- Handshakes rows in from the interpolation filter and out to the SAD/cost stage.
- Tracks the one-cycle clipper register latency, applies backpressure, and signals block completion.

Parameters:
ROW_W, 6, width of row count and row index (max 63 rows per block)
MODE_2D, 2'd2, mode code that selects the shift-by-6 (second-stage 2D) clipping path

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle command pulse; sampled only in IDLE
mode  input  2  0=full-pel copy, 1=1D filtered, 2=2D filtered, 3=reserved (treated as 1D)
num_rows  input  ROW_W  rows in block; sampled with start
busy  output  1  high from accepted start until the done cycle inclusive
done  output  1  one-cycle pulse after the last row leaves the clipper
filt_valid  input  1  filter presents a row on the clipper inputs
filt_ready  output  1  controller accepts the row this cycle
clip_enable  output  1  to clipper enable; row captured into clipper output register
clip_pvso  output  1  to clipper clip_pvso select
out_valid  output  1  clipper outputs hold a valid row
out_ready  input  1  downstream consumes the row
row_idx  output  ROW_W  index of the row currently on the clipper outputs
last_row  output  1  qualifies out_valid: row_idx == num_rows-1
stall_cycles  output  16  performance counter (see Optional Feature)

Behaviour:
- Clock and reset are decided: one clock named clock; reset_n is asynchronous and active-low.
- Reset values: FSM=IDLE, busy=0, done=0, filt_ready=0, clip_enable=0, clip_pvso=0, out_valid=0, row_idx=0, last_row=0, stall_cycles=0.
- Reset asserted mid-block aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches mode and num_rows.
  - num_rows=0 -> DONE (done pulse next cycle, no rows moved); otherwise -> RUN.
  - start while not IDLE is ignored.
- clip_pvso:
  - Registered from the latched mode: 1 iff mode==MODE_2D.
  - Stable for the whole block, valid from the first RUN cycle.
  - Returns to 0 in IDLE.
- RUN:
  - filt_ready = !out_valid | out_ready (single-stage pipe, full throughput).
  - clip_enable = filt_valid & filt_ready (combinational).
  - An accepted row sets out_valid=1 on the next cycle.
  - out_valid clears on out_ready with no new accept.
  - Simultaneous accept and consume keeps out_valid=1 and loads the new row.
- Stall: out_valid & !out_ready forces filt_ready=0 and clip_enable=0; the clipper register holds the row unchanged.
- Row counting:
  - Accept counter increments on each accept.
  - row_idx increments on each consume and is 0 for the first row.
  - The accept of row num_rows-1 -> DRAIN; filt_ready=0 thereafter.
- DRAIN: consume of the row with last_row=1 -> DONE.
- DONE: done=1 and busy=1 for one cycle -> IDLE; busy=0 next cycle.
- Latency: row accepted at cycle N is on the clipper outputs with out_valid=1 at cycle N+1.
- Throughput: 1 row/cycle when out_ready stays high.
- Counters do not wrap: at most 2^ROW_W-1 rows per block.

Optional Feature:
- Macro: CLIPPER_SEQ_STALL_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with out_valid & !out_ready while busy.
  - Saturates at 16'hFFFF.
  - Clears on accepted start; holds after done.
- Undefined: no counter logic; stall_cycles tied to 0.

Test Plan:
- Reset, then start mode=1 num_rows=4, filt_valid=1, out_ready=1 -> clip_pvso=0, clip_enable high 4 cycles, out_valid rows 0..3 on consecutive cycles, last_row with row 3, done pulse 1 cycle after row 3, busy low after.
- start mode=2 num_rows=3 -> clip_pvso=1 throughout RUN/DRAIN; 0 after done.
- num_rows=5, out_ready low for cycles 2-4 after first out_valid -> filt_ready=0 and clip_enable=0 during stall, row_idx held, no row lost or duplicated, 5 consumes total; stall_cycles=3 with macro defined, 0 without.
- start with num_rows=0 -> done pulse next cycle, clip_enable never asserted, out_valid never asserted.
- Second start pulse mid-block -> ignored; original block completes with its row count; single done pulse.
- reset_n low during RUN with row 2 of 6 outstanding -> all outputs at reset values asynchronously; no done pulse; new start after release runs normally.

Source files
------------

// File: rtl/clipper_seq_ctrl.sv
// ============================================================================
// Module      : clipper_seq_ctrl
// Description : Block sequencer for the 27-lane FME clipper: row handshake,
//               clip_pvso select, single-stage register tracking, done pulse.
//               Optional stall counter enabled by CLIPPER_SEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clipper_seq_ctrl #(
  parameter int         ROW_W   = 6,
  parameter logic [1:0] MODE_2D = 2'd2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [ROW_W-1:0] num_rows,
  output logic             busy,
  output logic             done,
  input  logic             filt_valid,
  output logic             filt_ready,
  output logic             clip_enable,
  output logic             clip_pvso,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] row_idx,
  output logic             last_row,
  output logic [15:0]      stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [ROW_W-1:0] r_num_rows;
  logic [ROW_W-1:0] r_acc_cnt;
  logic [ROW_W-1:0] r_row_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_pvso;
  logic             r_out_valid;

  logic             w_filt_ready;
  logic             w_accept;
  logic             w_consume;
  logic             w_start_acc;
  logic [ROW_W-1:0] w_last_idx;

  assign w_last_idx   = r_num_rows - {{(ROW_W-1){1'b0}}, 1'b1};
  // Single-stage pipe: a new row may enter whenever the register empties this cycle
  assign w_filt_ready = (r_state == S_RUN) & (~r_out_valid | out_ready);
  assign w_accept     = filt_valid & w_filt_ready;
  assign w_consume    = r_out_valid & out_ready;
  assign w_start_acc  = (r_state == S_IDLE) & start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_num_rows  <= '0;
      r_acc_cnt   <= '0;
      r_row_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pvso      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end

      if (w_consume) begin
        r_row_idx <= r_row_idx + {{(ROW_W-1){1'b0}}, 1'b1};
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_rows <= num_rows;
            r_pvso     <= (mode == MODE_2D);
            r_busy     <= 1'b1;
            r_acc_cnt  <= '0;
            r_row_idx  <= '0;
            if (num_rows == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (r_acc_cnt == w_last_idx) begin
              r_state <= S_DRAIN;
            end else begin
              r_acc_cnt <= r_acc_cnt + {{(ROW_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_DRAIN: begin
          if (w_consume && (r_row_idx == w_last_idx)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_pvso    <= 1'b0;
          r_acc_cnt <= '0;
          r_row_idx <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign filt_ready  = w_filt_ready;
  assign clip_enable = w_accept;
  assign clip_pvso   = r_pvso;
  assign out_valid   = r_out_valid;
  assign row_idx     = r_row_idx;
  assign last_row    = r_out_valid & (r_row_idx == w_last_idx);

`ifdef CLIPPER_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'd0;
    end else if (w_start_acc) begin
      r_stall_cnt <= 16'd0;
    end else if (r_busy && r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clipper_seq_ctrl.sv
// ============================================================================
// Module      : tb_clipper_seq_ctrl
// Description : Scoreboard bench for clipper_seq_ctrl; directed block vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clipper_seq_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic [5:0]  num_rows;
  logic        busy;
  logic        done;
  logic        filt_valid;
  logic        filt_ready;
  logic        clip_enable;
  logic        clip_pvso;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  row_idx;
  logic        last_row;
  logic [15:0] stall_cycles;

  clipper_seq_ctrl #(.ROW_W(6), .MODE_2D(2'd2)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .num_rows     (num_rows),
    .busy         (busy),
    .done         (done),
    .filt_valid   (filt_valid),
    .filt_ready   (filt_ready),
    .clip_enable  (clip_enable),
    .clip_pvso    (clip_pvso),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .row_idx      (row_idx),
    .last_row     (last_row),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
    logic       pvso;
  } row_t;

  row_t sb_q[$];
  int   done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int cons_cnt = 0;
  int cyc      = 0;
  int cyc_last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as rows and done pulses appear
  initial begin
    logic prev_acc;
    row_t e;
    int   n;
    prev_acc = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) chk("accept_to_out_valid", out_valid, 1);
        prev_acc = clip_enable;
        if (clip_enable) acc_cnt++;
        if (out_valid && out_ready) begin
          cons_cnt++;
          if (sb_q.size() == 0) begin
            chk("unexpected_row", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            chk("row_idx", row_idx, e.idx);
            chk("last_row", last_row, e.last);
            chk("row_pvso", clip_pvso, e.pvso);
          end
          if (last_row) cyc_last = cyc;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", done_q.size(), 1);
          end else begin
            n = done_q.pop_front();
            chk("busy_at_done", busy, 1);
            if (n > 0) chk("done_after_last_row", cyc - cyc_last, 1);
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_filt_ready"}, filt_ready, 0);
    chk({tag, "_clip_enable"}, clip_enable, 0);
    chk({tag, "_clip_pvso"}, clip_pvso, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_row_idx"}, row_idx, 0);
    chk({tag, "_last_row"}, last_row, 0);
    chk({tag, "_stall_cycles"}, stall_cycles, 0);
  endtask

  // Runs one block; k counts cycles from the first out_valid. Rows k in [st_lo,st_hi] see out_ready=0.
  task automatic run_block(input logic [1:0] m, input int n, input int st_lo, input int st_hi,
                           input int extra_k);
    int   a0, c0, k, stall_len, exp_stall;
    bit   got;
    logic exp_pvso;
    a0 = acc_cnt; c0 = cons_cnt; k = -1; stall_len = 0; got = 0;
    exp_pvso = (m == 2'd2);
    @(posedge clock); #1;
    start = 1'b1; mode = m; num_rows = 6'(n); filt_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < n; i++) sb_q.push_back('{idx: 6'(i), last: (i == n - 1), pvso: exp_pvso});
    done_q.push_back(n);
    for (int it = 0; it < 300; it++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (k >= 0) k++;
      else if (out_valid) k = 0;
      if (it == 0 && n == 0) chk("zero_rows_done_next", done, 1);
      if (done) begin
        got = 1;
        if (n > 0) chk("first_row_to_done", k, n + stall_len);
        break;
      end
      if (busy) chk("pvso_stable", clip_pvso, exp_pvso);
      out_ready = !(k >= 0 && k >= st_lo && k <= st_hi);
      if (!out_ready) begin
        stall_len++;
        #1;
        chk("stall_filt_ready", filt_ready, 0);
        chk("stall_clip_enable", clip_enable, 0);
        chk("stall_row_idx", row_idx, st_lo);
      end
      if (k == extra_k) begin
        start = 1'b1; mode = 2'd2; num_rows = 6'd2;
      end
    end
    chk("done_timeout", got, 1);
    out_ready = 1'b1; filt_valid = 1'b0;
    @(posedge clock); #1;
    chk("busy_after_done", busy, 0);
    chk("done_single_pulse", done, 0);
    chk("pvso_idle", clip_pvso, 0);
    chk("accept_count", acc_cnt - a0, n);
    chk("consume_count", cons_cnt - c0, n);
`ifdef CLIPPER_SEQ_STALL_CNT_EN
    exp_stall = stall_len;
`else
    exp_stall = 0;
`endif
    chk("stall_cycles", stall_cycles, exp_stall);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 2'd0; num_rows = 6'd0;
    filt_valid = 1'b0; out_ready = 1'b1;
    #2;
    check_reset_vals("reset");
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    run_block(2'd1, 4, -1, -2, -1);   // 1D, full throughput
    run_block(2'd2, 3, -1, -2, -1);   // 2D path
    run_block(2'd1, 5, 2, 4, -1);     // three-cycle stall on row 2
    run_block(2'd1, 0, -1, -2, -1);   // empty block
    run_block(2'd1, 4, -1, -2, 1);    // stray start mid-block
    run_block(2'd3, 2, -1, -2, -1);   // reserved mode behaves as 1D

    // Abort with row 2 of 6 sitting on the clipper outputs
    @(posedge clock); #1;
    start = 1'b1; mode = 2'd1; num_rows = 6'd6; filt_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb_q.push_back('{idx: 6'(i), last: (i == 5), pvso: 1'b0});
    done_q.push_back(6);
    @(posedge clock); #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    chk("abort_row2_valid", out_valid, 1);
    chk("abort_row2_idx", row_idx, 2);
    sb_q.delete();
    done_q.delete();
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_abort");
    repeat (2) @(posedge clock);
    #1;
    chk("abort_hold_done", done, 0);
    chk("abort_hold_busy", busy, 0);
    reset_n = 1'b1;
    filt_valid = 1'b0;

    run_block(2'd1, 3, -1, -2, -1);   // normal operation after abort

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
